// File: rtl/ro_row_sequencer.sv
// Frame readout row sequencer: walks ROW_FIRST..ROW_LAST (modulo 2^ROW_W), handshaking each row
// with the row decoder and the column/ADC stage. Outputs are registered from the state being entered.
//   state      | meaning
//   IDLE       | no frame, all outputs low
//   REQ        | row request up, waiting for decoder done
//   TRIG       | one-cycle readout trigger
//   WAIT_RO    | waiting for column/ADC completion
//   RELEASE    | request dropped, waiting for decoder done to fall
//   GAP        | programmable inter-row gap
//   DONE       | one-cycle frame-done pulse
//   ABORT_WAIT | aborted, waiting for decoder done to fall
module ro_row_sequencer #(
    parameter int ROW_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             START,
    input  logic             ABORT,
    input  logic [ROW_W-1:0] ROW_FIRST,
    input  logic [ROW_W-1:0] ROW_LAST,
    input  logic [31:0]      T_ROW_GAP,
    output logic             SET_ROW_RO,
    output logic [ROW_W-1:0] ROWADD_RO,
    input  logic             SET_ROW_DONE_RO,
    output logic             RO_TRIG,
    input  logic             RO_DONE,
    output logic             FRAME_BUSY,
    output logic             FRAME_DONE
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_REQ        = 3'd1;
    localparam logic [2:0] S_TRIG       = 3'd2;
    localparam logic [2:0] S_WAIT_RO    = 3'd3;
    localparam logic [2:0] S_RELEASE    = 3'd4;
    localparam logic [2:0] S_GAP        = 3'd5;
    localparam logic [2:0] S_DONE       = 3'd6;
    localparam logic [2:0] S_ABORT_WAIT = 3'd7;

    logic [2:0]       state, state_nxt;
    logic [ROW_W-1:0] row, row_nxt;
    logic [ROW_W-1:0] last_r, last_nxt;
    logic [31:0]      gap_cnt, gap_nxt;
    logic             abort_hit;

    assign abort_hit = ABORT && (state == S_REQ || state == S_TRIG || state == S_WAIT_RO ||
                                 state == S_RELEASE || state == S_GAP);

    always_comb begin
        state_nxt = state;
        row_nxt   = row;
        last_nxt  = last_r;
        gap_nxt   = gap_cnt;
        if (abort_hit) begin
            state_nxt = S_ABORT_WAIT;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        row_nxt   = ROW_FIRST;
                        last_nxt  = ROW_LAST;
                        state_nxt = S_REQ;
                    end
                end
                S_REQ: begin
                    if (SET_ROW_DONE_RO) state_nxt = S_TRIG;
                end
                S_TRIG: state_nxt = S_WAIT_RO;
                S_WAIT_RO: begin
                    if (RO_DONE) state_nxt = S_RELEASE;
                end
                S_RELEASE: begin
                    // row advances only once the decoder has let go of the current row
                    if (!SET_ROW_DONE_RO) begin
                        if (row == last_r) begin
                            state_nxt = S_DONE;
                        end else begin
                            row_nxt   = row + 1'b1;
                            gap_nxt   = '0;
                            state_nxt = S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    gap_nxt = gap_cnt + 32'd1;
                    if (gap_cnt >= T_ROW_GAP) state_nxt = S_REQ;
                end
                S_DONE: state_nxt = S_IDLE;
                S_ABORT_WAIT: begin
                    if (!SET_ROW_DONE_RO) state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            row        <= '0;
            last_r     <= '0;
            gap_cnt    <= '0;
            SET_ROW_RO <= 1'b0;
            ROWADD_RO  <= '0;
            RO_TRIG    <= 1'b0;
            FRAME_BUSY <= 1'b0;
            FRAME_DONE <= 1'b0;
        end else begin
            state      <= state_nxt;
            row        <= row_nxt;
            last_r     <= last_nxt;
            gap_cnt    <= gap_nxt;
            SET_ROW_RO <= (state_nxt == S_REQ) || (state_nxt == S_TRIG) || (state_nxt == S_WAIT_RO);
            ROWADD_RO  <= (state_nxt == S_IDLE) ? '0 : row_nxt;
            RO_TRIG    <= (state_nxt == S_TRIG);
            FRAME_BUSY <= (state_nxt != S_IDLE);
            FRAME_DONE <= (state_nxt == S_DONE);
        end
    end

endmodule
